zap_decode_irq_sequencer: RTL
=============================

# zap_decode_irq_sequencer

Interrupt-boundary controller placed between fetch and the LDM/STM decode sequencer. It samples IRQ/FIQ and applies the CPSR masks and FIQ-over-IRQ priority. It attaches a taken interrupt to exactly one instruction at an instruction boundary, then blanks the decode input until writeback flushes for exception entry. A holdoff window after entry guarantees forward progress inside the handler.

## Interface
- TIMEOUT, 64: max advancing cycles in WAIT_FLUSH before abandoning the attach.
- HOLDOFF, 2: advancing cycles after exception-entry flush during which no interrupt is attached.
- i_clk  in  1  ZAP clock.
- i_reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_instruction  in  35  instruction from fetch.
- i_instruction_valid  in  1  fetch valid.
- i_irq, i_fiq  in  1 each  level interrupt requests.
- i_cpsr_i, i_cpsr_f  in  1 each  CPSR mask bits; 1 = masked.
- i_stall_from_decode  in  1  downstream sequencer mid-sequence (not an instruction boundary).
- i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_issue_stall  in  1 each  pipeline control.
- o_instruction  out  35  instruction to decode sequencer.
- o_instruction_valid  out  1  valid to decode sequencer.
- o_irq, o_fiq  out  1 each  interrupt tag for o_instruction (one-hot or zero).
- o_stall_from_irq  out  1  fetch must hold its output.
- o_timeout  out  1  one-cycle pulse on WAIT_FLUSH timeout.

## Operation
- Pending regs: pend_fiq <= i_fiq & ~i_cpsr_f, pend_irq <= i_irq & ~i_cpsr_i; updated every cycle, including during stalls.
- "Advance" = none of clear_from_writeback, data_stall, clear_from_alu, stall_from_shifter, issue_stall. State and counter updates follow the priority reset > clear_from_writeback > data_stall > clear_from_alu > shifter stall > issue stall.
- Boundary = i_instruction_valid & ~i_stall_from_decode.
- IDLE: o_instruction = i_instruction, valid passes through, o_stall_from_irq=0.
  - If boundary & pend_fiq: o_fiq=1.
  - Else if boundary & pend_irq: o_irq=1.
  - If tagged and advance: go to WAIT_FLUSH, counter=0.
  - If tagged and stalled: stay in IDLE; re-evaluate next cycle (mask changes honoured).
- WAIT_FLUSH: o_instruction_valid=0, o_irq=o_fiq=0, o_stall_from_irq=1.
  - clear_from_writeback: go to HOLDOFF, counter=HOLDOFF.
  - Else clear_from_alu (tagged instruction squashed): go to IDLE; the interrupt is re-attached if still pending.
  - Else on advance: counter+1. When counter reaches TIMEOUT-1, go to IDLE and pulse o_timeout.
- HOLDOFF: transparent pass-through with o_irq=o_fiq=0.
  - Counter decrements on advance; at 0, go to IDLE.
  - clear_from_writeback reloads HOLDOFF.
  - clear_from_alu does not exit HOLDOFF.
  - If HOLDOFF=0, go from WAIT_FLUSH directly to IDLE.
- Counter width: $clog2(max(TIMEOUT,HOLDOFF)+1). Saturating, never wraps.
- While i_reset_n=0: state=IDLE, counter=0, pend_*=0, o_instruction_valid=0, o_irq=o_fiq=0, o_stall_from_irq=0, o_timeout=0. o_instruction = i_instruction (don't-care).

## Timing
- Latency from interrupt input to tag: 1 cycle (pending register), then the tag appears combinationally on the next boundary.
- The instruction path is combinational; the block adds no latency when untagged.
- The tag is held for as many cycles as the pipeline stalls. The FSM leaves IDLE only on an advancing cycle.
- Reset assertion mid-WAIT_FLUSH or mid-HOLDOFF returns to IDLE immediately (async). Deassertion takes effect at the next i_clk edge.
- clear_from_writeback together with a new boundary in IDLE: no state change, no tag accepted (the instruction is flushed).
- o_timeout is high for exactly the cycle of the WAIT_FLUSH→IDLE timeout transition.

## Test plan
- Basic IRQ: i_irq=1, i_cpsr_i=0, a stream of valid instructions → o_irq=1 on the 2nd cycle's instruction, then valid=0 and o_stall_from_irq=1. Pulse clear_from_writeback → 2 untagged pass-through cycles, then IDLE.
- FIQ priority and masks: irq=fiq=1 with cpsr_f=0 → o_fiq=1, o_irq=0. With cpsr_f=1 → o_irq=1. With both masked → no tag ever.
- Boundary respect: i_stall_from_decode=1 for 5 cycles with irq pending → o_irq=0 throughout; it tags on the first cycle after the stall drops.
- Stall hold: issue_stall high 3 cycles while tagged → o_irq stays 1 and the state stays IDLE; on release it moves to WAIT_FLUSH.
- Squash and timeout: clear_from_alu in WAIT_FLUSH → IDLE, re-tag next boundary. With TIMEOUT=4 and no flush → o_timeout pulses after 4 advancing cycles, then IDLE.
- Async reset mid-WAIT_FLUSH → outputs immediately 0. After release, the first boundary with pending irq tags after 1 cycle.

Source files
------------

// File: rtl/zap_decode_irq_sequencer.sv
// Interrupt-boundary controller between fetch and the LDM/STM decode sequencer.
// Attaches a masked, prioritised IRQ/FIQ to one instruction, then blanks decode until the entry flush.
module zap_decode_irq_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int HOLDOFF = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [34:0] i_instruction,
    input  logic        i_instruction_valid,
    input  logic        i_irq,
    input  logic        i_fiq,
    input  logic        i_cpsr_i,
    input  logic        i_cpsr_f,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_issue_stall,
    output logic [34:0] o_instruction,
    output logic        o_instruction_valid,
    output logic        o_irq,
    output logic        o_fiq,
    output logic        o_stall_from_irq,
    output logic        o_timeout
);

    localparam int CMAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLDOFF);
    localparam logic [CW-1:0] CNT_MAX = CW'(CMAX);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_FLUSH, S_HOLDOFF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_fiq, pend_irq;
    logic          advance, boundary;

    assign advance  = ~(i_clear_from_writeback | i_data_stall | i_clear_from_alu |
                        i_stall_from_shifter | i_issue_stall);
    assign boundary = i_instruction_valid & ~i_stall_from_decode;

    // Pending requests keep sampling through stalls so mask changes are honoured.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend_fiq <= 1'b0;
            pend_irq <= 1'b0;
        end else begin
            pend_fiq <= i_fiq & ~i_cpsr_f;
            pend_irq <= i_irq & ~i_cpsr_i;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        o_instruction       = i_instruction;
        o_instruction_valid = i_instruction_valid & i_reset_n;
        o_irq               = 1'b0;
        o_fiq               = 1'b0;
        o_stall_from_irq    = 1'b0;
        o_timeout           = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_fiq = boundary & pend_fiq;
                o_irq = boundary & pend_irq & ~pend_fiq;
                // A stalled tag stays in IDLE and is re-evaluated next cycle.
                if ((o_fiq | o_irq) & advance) begin
                    state_d = S_WAIT_FLUSH;
                    cnt_d   = '0;
                end
            end
            S_WAIT_FLUSH: begin
                o_instruction_valid = 1'b0;
                o_stall_from_irq    = 1'b1;
                if (i_clear_from_writeback) begin
                    if (HOLDOFF == 0) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = HOLD_LD;
                    end
                end else if (i_data_stall) begin
                    state_d = S_WAIT_FLUSH;
                end else if (i_clear_from_alu) begin
                    // Tagged instruction squashed; the request re-attaches from IDLE.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (advance) begin
                    if (cnt_q == TO_LAST) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        o_timeout = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HOLDOFF: begin
                if (i_clear_from_writeback) begin
                    cnt_d = HOLD_LD;
                end else if (advance) begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
